// File: rtl/gouram_trace_pkg.sv
// Shared constants, drain FSM state type and beat-slicing helper for the
// Gouram trace drain.
package gouram_trace_pkg;

  localparam int TRACE_RECORD_WIDTH = 128;
  localparam int TRACE_WORD_WIDTH   = 32;
  localparam int BEATS_PER_RECORD   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } drain_state_t;

  // Select beat k of a record: beat 0 is the least significant word.
  function automatic logic [TRACE_WORD_WIDTH-1:0] beat_slice(
    input logic [TRACE_RECORD_WIDTH-1:0] rec,
    input logic [1:0]                    beat
  );
    logic [TRACE_WORD_WIDTH-1:0] w;
    case (beat)
      2'd0:    w = rec[31:0];
      2'd1:    w = rec[63:32];
      2'd2:    w = rec[95:64];
      2'd3:    w = rec[127:96];
      default: w = rec[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with clear and registered level.
// The caller never pushes into a full FIFO unless it pops in the same cycle,
// and never pops an empty one.
module gouram_trace_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LW'(0);
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Record storage; contents are meaningless while the level says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/gouram_trace_drain.sv
// Gouram trace drain: captures 128-bit trace records into a FIFO and
// serialises them as four 32-bit beats on a valid/ready stream, with drop
// counting and a flush that never truncates a record in flight.
module gouram_trace_drain #(
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [127:0]                  trace_data_i,
  input  logic                          trace_capture_enable_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  output logic [31:0]                   word_o,
  output logic                          word_valid_o,
  input  logic                          word_ready_i,
  output logic                          word_last_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count_o,
  output logic                          busy_o
);

  import gouram_trace_pkg::*;

  localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

  drain_state_t                state_q, state_d;
  logic [1:0]                  beat_q, beat_d;
  logic                        overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic [TRACE_RECORD_WIDTH-1:0] head_s;
  logic [LW-1:0]                 level_s;
  logic                          valid_s;
  logic                          hs_s;
  logic                          pop_s;
  logic                          push_req_s;
  logic                          push_s;
  logic                          drop_s;
  logic                          clear_s;
  logic                          remain_s;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    logic [DROP_CNT_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + DROP_CNT_WIDTH'(1);
    end
    return r;
  endfunction

  gouram_trace_fifo #(
    .WIDTH (TRACE_RECORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_s),
    .push_i  (push_s),
    .data_i  (trace_data_i),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .level_o (level_s)
  );

  // Handshake, push acceptance and drop decisions for this cycle.
  always_comb begin
    valid_s    = (state_q == SEND) || (state_q == DRAIN);
    hs_s       = valid_s & word_ready_i;
    pop_s      = hs_s & (beat_q == 2'd3);
    clear_s    = (state_q == CLEAR);
    push_req_s = trace_capture_enable_i & enable_i & ~clear_s;
    // A full FIFO still accepts when the head leaves on this same edge.
    push_s     = push_req_s & ((level_s < DEPTH_LVL) | pop_s);
    drop_s     = push_req_s & ~push_s;
    // Another record is waiting once the head is popped.
    remain_s   = (level_s > LW'(1)) | push_s;
  end

  // Drain FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = CLEAR;
        end else if (level_s != LW'(0)) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (flush_i) begin
          // A record finishing on this edge is complete, so clear straight
          // away; a record already started must be finished in DRAIN.
          if (pop_s) begin
            state_d = CLEAR;
          end else if ((beat_q == 2'd0) && !hs_s) begin
            state_d = CLEAR;
          end else begin
            state_d = DRAIN;
          end
        end else if (pop_s) begin
          state_d = remain_s ? SEND : IDLE;
        end else begin
          state_d = SEND;
        end
      end
      DRAIN: begin
        if (pop_s) begin
          state_d = CLEAR;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counter and drop bookkeeping next-state.
  always_comb begin
    beat_d     = beat_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_s) begin
      beat_d     = 2'd0;
      overflow_d = 1'b0;
      drop_cnt_d = {DROP_CNT_WIDTH{1'b0}};
    end else begin
      if (hs_s) begin
        beat_d = beat_q + 2'd1;
      end else begin
        beat_d = beat_q;
      end
      if (drop_s) begin
        overflow_d = 1'b1;
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Output decode from registered state; the word is masked to zero when idle.
  always_comb begin
    word_valid_o = valid_s;
    word_last_o  = 1'b0;
    word_o       = 32'd0;
    if (valid_s) begin
      word_o      = beat_slice(head_s, beat_q);
      word_last_o = (beat_q == 2'd3);
    end else begin
      word_o      = 32'd0;
      word_last_o = 1'b0;
    end
    fifo_level_o = level_s;
    overflow_o   = overflow_q;
    drop_count_o = drop_cnt_q;
    busy_o       = (level_s != LW'(0)) || (state_q != IDLE);
  end

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Self-checking bench for gouram_trace_drain: a scoreboard of expected beats
// is filled as records are strobed in and drained by a stream monitor.
module tb_gouram_trace_drain;

  logic         clk;
  logic         rst;
  logic [127:0] trace_data;
  logic         cap;
  logic         enable;
  logic         flush;
  logic [31:0]  word;
  logic         valid;
  logic         ready;
  logic         last;
  logic [2:0]   level;
  logic         overflow;
  logic [15:0]  drop;
  logic         busy;

  gouram_trace_drain #(
    .FIFO_DEPTH     (4),
    .DROP_CNT_WIDTH (16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .trace_data_i           (trace_data),
    .trace_capture_enable_i (cap),
    .enable_i               (enable),
    .flush_i                (flush),
    .word_o                 (word),
    .word_valid_o           (valid),
    .word_ready_i           (ready),
    .word_last_o            (last),
    .fifo_level_o           (level),
    .overflow_o             (overflow),
    .drop_count_o           (drop),
    .busy_o                 (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  logic [32:0] exp_q [$];
  logic        stall_q = 1'b0;
  logic [31:0] stall_word;
  logic        stall_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_record(input logic [127:0] rec);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({(k == 3), rec[32*k +: 32]});
    end
  endtask

  // Strobe one record for one cycle; caller is just after a rising edge.
  task automatic strobe(input logic [127:0] rec, input bit acc);
    trace_data = rec;
    cap = 1'b1;
    if (acc) push_record(rec);
    @(posedge clk); #1;
    cap = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    chk("valid_wait", 64'(valid), 64'd1);
  endtask

  task automatic wait_done(input int budget, input bit gap_chk);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_drop", 64'(busy), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    if (gap_chk) chk("busy_gap", 64'(cyc - last_hs_cyc), 64'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_word"}, 64'(word), 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drop"}, 64'(drop), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Stream monitor: scoreboard pops on each handshake, stall stability checks.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (stall_q) begin
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_word", 64'(word), 64'(stall_word));
        chk("hold_last", 64'(last), 64'(stall_last));
      end
      if (valid) begin
        if (ready) begin
          chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_word", 64'(word), 64'(e[31:0]));
            chk("beat_last", 64'(last), 64'(e[32]));
          end
          hs_count++;
          if (last) last_hs_cyc = cyc;
          stall_q = 1'b0;
        end else begin
          stall_q    = 1'b1;
          stall_word = word;
          stall_last = last;
        end
      end else begin
        chk("idle_word", 64'(word), 64'd0);
        stall_q = 1'b0;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rec;
    int hs0;
    rst = 1'b1; cap = 1'b0; enable = 1'b1; flush = 1'b0; ready = 1'b0;
    trace_data = 128'd0;
    @(posedge clk); @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single record with ready held high, checking capture latency.
    ready = 1'b1;
    strobe(128'h88887777_66665555_44443333_22221111, 1'b1);
    @(negedge clk);
    chk("lat_level", 64'(level), 64'd1);
    chk("lat_valid_n1", 64'(valid), 64'd0);
    @(negedge clk);
    chk("lat_valid_n2", 64'(valid), 64'd1);
    wait_done(40, 1'b1);

    // Back-pressure for 5 cycles while beat 2 is presented.
    @(posedge clk); #1;
    ready = 1'b0;
    strobe(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b1);
    wait_valid(20);
    hs0 = hs_count;
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; ready = 1'b0;
    repeat (5) @(posedge clk);
    #1; ready = 1'b1;
    wait_done(40, 1'b0);
    chk("bp_beats", 64'(hs_count - hs0), 64'd4);

    // Overflow: six strobes into a depth-4 FIFO with the sink stalled.
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rec = {32'hC3000000 | 32'(i), 32'hC2000000 | 32'(i),
             32'hC1000000 | 32'(i), 32'hC0000000 | 32'(i)};
      strobe(rec, (i < 4));
    end
    @(negedge clk);
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_drop", 64'(drop), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    @(posedge clk); #1; ready = 1'b1;
    wait_done(100, 1'b0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a push on the beat-3 handshake.
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec = {32'hD3000000 | 32'(i), 32'hD2000000 | 32'(i),
             32'hD1000000 | 32'(i), 32'hD0000000 | 32'(i)};
      strobe(rec, 1'b1);
    end
    wait_valid(20);
    chk("full_level", 64'(level), 64'd4);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    strobe(128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 1'b1);
    ready = 1'b0;
    @(negedge clk);
    chk("full_push_level", 64'(level), 64'd4);
    chk("full_push_drop", 64'(drop), 64'd2);
    @(posedge clk); #1; ready = 1'b1;
    wait_done(100, 1'b0);

    // Flush while beat 1 of the first of three records is presented.
    @(posedge clk); #1;
    ready = 1'b0;
    strobe(128'hF0A3F0A3_F0A2F0A2_F0A1F0A1_F0A0F0A0, 1'b1);
    strobe(128'hF0B3F0B3_F0B2F0B2_F0B1F0B1_F0B0F0B0, 1'b1);
    strobe(128'hF0C3F0C3_F0C2F0C2_F0C1F0C1_F0C0F0C0, 1'b1);
    wait_valid(20);
    chk("pre_flush_drop", 64'(drop), 64'd2);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 8; i++) void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    ready = 1'b1;
    wait_done(40, 1'b0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_drop", 64'(drop), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    repeat (6) @(negedge clk);
    chk("flush_quiet", 64'(valid), 64'd0);

    // Reset while beat 2 is presented, then a fresh record.
    @(posedge clk); #1;
    ready = 1'b0;
    strobe(128'h97979797_96969696_95959595_94949494, 1'b1);
    wait_valid(20);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk); #1; ready = 1'b1;
    strobe(128'hA7A7A7A7_A6A6A6A6_A5A5A5A5_A4A4A4A4, 1'b1);
    wait_done(40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
